// File: rtl/spi_ram_pkg.sv
// Shared constants and state encoding for the SPI SRAM responder.
// Mode-register opcodes are only decoded when SPI_RAM_RESPONDER_MODE_EN is defined.
package spi_ram_pkg;

  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WRSR  = 8'h01;

  // Mode[7:6] field values; anything other than byte mode runs sequentially
  localparam logic [1:0] MODE_BYTE  = 2'b00;
  localparam logic [1:0] MODE_SEQ   = 2'b01;
  localparam logic [7:0] MODE_RESET = 8'h40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_READ,
    ST_WRITE,
    ST_IGNORE,
    ST_RDSR,
    ST_WRSR
  } state_t;

endpackage

// File: rtl/spi_ram_responder_if.sv
// Serial bus between an SPI initiator (master) and the SRAM responder (slave).
interface spi_ram_responder_if;

  logic spi_clk;
  logic spi_select;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_clk, output spi_select, output spi_mosi, input spi_miso);
  modport slave  (input spi_clk, input spi_select, input spi_mosi, output spi_miso);

endinterface

// File: rtl/spi_sync_edge.sv
// Optional N-flop synchronizer followed by a one-cycle rise/fall pulse detector.
// The detector history is never reset so it cannot invent an edge after reset.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic prev;

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign sync = din;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] chain;
      always_ff @(posedge clk) begin
        chain[0] <= din;
        for (int i = 1; i < SYNC_STAGES; i++) chain[i] <= chain[i-1];
      end
      assign sync = chain[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk) prev <= sync;

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_ram_responder.sv
// Mode-0 SPI SRAM target (READ 0x03 / WRITE 0x02) with a backdoor preload/inspect port.
// Define SPI_RAM_RESPONDER_MODE_EN to add the RDSR/WRSR mode register and byte mode.
module spi_ram_responder
  import spi_ram_pkg::*;
#(
  parameter int ADDR_BITS   = 16,
  parameter int DEPTH       = 256,
  parameter int SYNC_STAGES = 2,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_ram_responder_if.slave   spi,
  output logic                 active,
  input  logic                 bd_we,
  input  logic [AW-1:0]        bd_addr,
  input  logic [7:0]           bd_wdata,
  output logic [7:0]           bd_rdata
);

  localparam logic [5:0] ADDR_LAST = 6'(ADDR_BITS - 1);

  logic       sck_rise, sck_fall, sel_s, sel_fall, mosi_s;
  logic       sck_level_unused, sel_rise_unused;
  logic [1:0] mosi_edge_unused;

  state_t     state, state_n;
  logic [5:0] bit_cnt;
  logic [2:0] tx_cnt;
  logic [6:0] shift_in;
  logic [7:0] rx_byte, tx_sh, wr_data, mem_q, src_byte;
  logic [AW-1:0] addr;
  logic       miso, op_read, wr_pend;
  logic       rd_state, data_state, cmd_done, byte_done, tx_load, seq_mode;
  logic [7:0] mem [DEPTH];

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
    .clk(clk), .din(spi.spi_clk), .sync(sck_level_unused), .rise(sck_rise), .fall(sck_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sel (
    .clk(clk), .din(spi.spi_select), .sync(sel_s), .rise(sel_rise_unused), .fall(sel_fall));
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosi (
    .clk(clk), .din(spi.spi_mosi), .sync(mosi_s),
    .rise(mosi_edge_unused[0]), .fall(mosi_edge_unused[1]));

`ifdef SPI_RAM_RESPONDER_MODE_EN
  logic [7:0] mode;
  assign seq_mode = (mode[7:6] != MODE_BYTE);
  assign src_byte = (state == ST_RDSR) ? mode : mem_q;
`else
  assign seq_mode = 1'b1;
  assign src_byte = mem_q;
`endif

  assign rx_byte    = {shift_in, mosi_s};
  assign rd_state   = (state == ST_READ) || (state == ST_RDSR);
  assign data_state = rd_state || (state == ST_WRITE) || (state == ST_WRSR);
  assign cmd_done   = (state == ST_CMD) && sck_rise && (bit_cnt == 6'd7);
  assign byte_done  = data_state && sck_rise && (bit_cnt == 6'd7);
  assign tx_load    = rd_state && sck_fall && (tx_cnt == 3'd0);
  assign spi.spi_miso = miso;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Deselect wins over everything; a frame only starts on a seen select fall
  always_comb begin
    state_n = state;
    if (sel_s) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (sel_fall) state_n = ST_CMD;
        ST_CMD: begin
          if (cmd_done) begin
            case (rx_byte)
              OP_READ, OP_WRITE: state_n = ST_ADDR;
`ifdef SPI_RAM_RESPONDER_MODE_EN
              OP_RDSR: state_n = ST_RDSR;
              OP_WRSR: state_n = ST_WRSR;
`endif
              default: state_n = ST_IGNORE;
            endcase
          end
        end
        ST_ADDR: if (sck_rise && bit_cnt == ADDR_LAST) state_n = op_read ? ST_READ : ST_WRITE;
        ST_READ, ST_WRITE: if (byte_done && !seq_mode) state_n = ST_IGNORE;
        ST_WRSR: if (byte_done) state_n = ST_IGNORE;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      tx_cnt  <= '0;
      active  <= 1'b0;
      miso    <= 1'b0;
      wr_pend <= 1'b0;
`ifdef SPI_RAM_RESPONDER_MODE_EN
      mode    <= MODE_RESET;
`endif
    end else begin
      active  <= (state_n != ST_IDLE);
      wr_pend <= byte_done && (state == ST_WRITE);
      if (state_n != state)    bit_cnt <= '0;
      else if (sck_rise)       bit_cnt <= (data_state && bit_cnt == 6'd7) ? 6'd0 : bit_cnt + 6'd1;
      if (state_n != state)       tx_cnt <= '0;
      else if (sck_fall && rd_state) tx_cnt <= tx_cnt + 3'd1;
      if (state_n == ST_IDLE) miso <= 1'b0;
      else if (sck_fall)      miso <= rd_state ? (tx_load ? src_byte[7] : tx_sh[7]) : 1'b0;
`ifdef SPI_RAM_RESPONDER_MODE_EN
      if (byte_done && state == ST_WRSR) mode <= rx_byte;
`endif
    end
  end

  // Address shifts straight into the low AW bits; the next read byte is prefetched
  // as soon as the current one is loaded into the output shifter
  always_ff @(posedge clk) begin
    if (sck_rise) shift_in <= rx_byte[6:0];
    if (cmd_done) op_read <= (rx_byte == OP_READ);
    if (byte_done && state == ST_WRITE) wr_data <= rx_byte;
    if (tx_load)                    tx_sh <= {src_byte[6:0], 1'b0};
    else if (sck_fall && rd_state)  tx_sh <= {tx_sh[6:0], 1'b0};
    if (state == ST_ADDR && sck_rise)                 addr <= {addr[AW-2:0], mosi_s};
    else if ((tx_load && state == ST_READ) || wr_pend) addr <= addr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (wr_pend)                mem[addr]    <= wr_data;
    else if (bd_we && !active)  mem[bd_addr] <= bd_wdata;
    mem_q <= mem[addr];
  end

  always_ff @(posedge clk) begin
    if (rst) bd_rdata <= '0;
    else     bd_rdata <= mem[bd_addr];
  end

endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed bench for spi_ram_responder; expected bytes go through a scoreboard queue.
// Mode-register steps are compiled in when SPI_RAM_RESPONDER_MODE_EN is defined.
module tb_spi_ram_responder;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       active, bd_we;
  logic [7:0] bd_addr, bd_wdata, bd_rdata;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  spi_ram_responder_if bus();

  spi_ram_responder #(.ADDR_BITS(16), .DEPTH(256), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .spi(bus), .active(active),
    .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata), .bd_rdata(bd_rdata));

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  task automatic sb_check(input string tag, input logic [7:0] obs);
    logic [7:0] want;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s: observed %h expected nothing queued", tag, obs);
    end else begin
      want = exp_q.pop_front();
      check(tag, obs, want);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = '0;
    for (int i = 0; i < n; i++) begin
      bus.spi_mosi = tx[7-i];
      ticks(HALF);
      rx = {rx[6:0], bus.spi_miso};
      bus.spi_clk = 1'b1;
      ticks(HALF);
      bus.spi_clk = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] r;
    spi_bits(b, 8, r);
  endtask

  task automatic sel_low();
    bus.spi_select = 1'b0;
    ticks(HALF);
    check("active_high", {7'd0, active}, 8'h01);
  endtask

  task automatic sel_high();
    ticks(HALF);
    bus.spi_select = 1'b1;
    ticks(8);
    check("active_low", {7'd0, active}, 8'h00);
  endtask

  task automatic recv(input int n, input string tag);
    logic [7:0] r;
    for (int i = 0; i < n; i++) begin
      spi_bits(8'h00, 8, r);
      sb_check(tag, r);
    end
  endtask

  task automatic read_frame(input logic [15:0] a, input int n, input string tag);
    sel_low();
    send(8'h03);
    send(a[15:8]);
    send(a[7:0]);
    recv(n, tag);
    sel_high();
  endtask

  task automatic rdsr_frame(input int n, input string tag);
    sel_low();
    send(8'h05);
    recv(n, tag);
    sel_high();
  endtask

  task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
    bd_addr  = a;
    bd_wdata = d;
    bd_we    = 1'b1;
    ticks(1);
    bd_we    = 1'b0;
  endtask

  task automatic bd_read(input logic [7:0] a, input string tag);
    bd_addr = a;
    ticks(1);
    sb_check(tag, bd_rdata);
  endtask

  initial begin
    logic [7:0] r;
    bus.spi_clk    = 1'b0;
    bus.spi_select = 1'b1;
    bus.spi_mosi   = 1'b0;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    rst = 1'b1;
    ticks(5);
    check("rst_miso", {7'd0, bus.spi_miso}, 8'h00);
    check("rst_active", {7'd0, active}, 8'h00);
    check("rst_bd_rdata", bd_rdata, 8'h00);
    rst = 1'b0;
    ticks(2);

    bd_write(8'h10, 8'hA5); bd_write(8'h11, 8'h3C);
    bd_write(8'hFF, 8'h77); bd_write(8'h00, 8'h88);
    bd_write(8'h20, 8'h00); bd_write(8'h21, 8'h00);
    bd_write(8'h30, 8'h00); bd_write(8'h31, 8'hEE);
    bd_write(8'h40, 8'h11);

    // sequential read
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C);
    read_frame(16'h0010, 2, "read_seq");

    // two-byte write, inspected through the backdoor
    sel_low(); send(8'h02); send(8'h00); send(8'h20); send(8'h12); send(8'h34); sel_high();
    exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    bd_read(8'h20, "write_b0"); bd_read(8'h21, "write_b1");

    // upper address bits masked, wrap from 0xFF to 0x00
    exp_q.push_back(8'h77); exp_q.push_back(8'h88);
    read_frame(16'h01FF, 2, "read_wrap");

    // partial trailing byte is dropped
    sel_low(); send(8'h02); send(8'h00); send(8'h30); send(8'h56);
    spi_bits(8'hFF, 5, r);
    sel_high();
    exp_q.push_back(8'h56); exp_q.push_back(8'hEE);
    bd_read(8'h30, "partial_full"); bd_read(8'h31, "partial_drop");

    // unknown opcode: silent, harmless, next frame normal
    sel_low(); send(8'h9F);
    for (int i = 0; i < 3; i++) begin
      spi_bits(8'hFF, 8, r);
      exp_q.push_back(8'h00);
      sb_check("ignore_miso", r);
    end
    sel_high();
    exp_q.push_back(8'hA5); exp_q.push_back(8'h12); exp_q.push_back(8'h34);
    bd_read(8'h10, "ignore_mem10"); bd_read(8'h20, "ignore_mem20"); bd_read(8'h21, "ignore_mem21");
    exp_q.push_back(8'h34);
    read_frame(16'h0021, 1, "after_ignore");

    // backdoor write while selected is refused
    sel_low(); bd_write(8'h40, 8'h99); sel_high();
    exp_q.push_back(8'h11);
    bd_read(8'h40, "bd_blocked");

    // reset mid-frame: stay idle until the next select fall
    sel_low(); send(8'h03); spi_bits(8'h00, 4, r);
    rst = 1'b1;
    ticks(3);
    check("midrst_active", {7'd0, active}, 8'h00);
    rst = 1'b0;
    spi_bits(8'h10, 4, r);
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    recv(2, "midrst_miso");
    check("midrst_idle", {7'd0, active}, 8'h00);
    ticks(HALF);
    bus.spi_select = 1'b1;
    ticks(8);
    exp_q.push_back(8'hA5);
    read_frame(16'h0010, 1, "after_midrst");

`ifdef SPI_RAM_RESPONDER_MODE_EN
    exp_q.push_back(8'h40);
    rdsr_frame(1, "rdsr_reset");
    sel_low(); send(8'h01); send(8'h00); sel_high();
    exp_q.push_back(8'hA5); exp_q.push_back(8'h00);
    read_frame(16'h0010, 2, "byte_mode");
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    rdsr_frame(2, "rdsr_zero");
    rst = 1'b1;
    ticks(3);
    rst = 1'b0;
    ticks(2);
    exp_q.push_back(8'h40);
    rdsr_frame(1, "rdsr_after_rst");
`else
    exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    rdsr_frame(2, "rdsr_unknown");
`endif

    check("sb_drain", 8'(exp_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
